// File: rtl/load_store_unit.sv
// Load/store unit: a four-state Moore FSM that moves words between a small private data
// memory and an external register bank (LOAD, STORE, MOVE, INCDP).
module load_store_unit #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [2:0]            rd,
    input  logic [2:0]            rs,
    input  logic [DATA_WIDTH-1:0] dptr,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] busb,
    output logic [2:0]            r_addr,
    output logic                  wr_en,
    output logic [2:0]            w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  busy,
    output logic                  done
);

    localparam int DEPTH = 2 ** DATA_WIDTH;
    localparam logic [2:0] DptrReg = 3'b010;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StWb   = 2'b10,
        StDone = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OpLoad  = 2'b00,
        OpStore = 2'b01,
        OpMove  = 2'b10,
        OpIncdp = 2'b11
    } op_t;

    state_t                r_state;
    state_t                w_state_next;
    op_t                   r_op;
    logic [2:0]            r_rd;
    logic [2:0]            r_rs;
    logic [DATA_WIDTH-1:0] r_data;
    logic [2:0]            r_w_addr;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_accept;
    logic                  w_exec_wb;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_exec_data;
    logic [2:0]            w_wb_addr;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StExec;
            StExec:  w_state_next = (r_op == OpStore) ? StDone : StWb;
            StWb:    w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // dptr is used as seen at the EXEC closing edge, not as latched at start.
    always_comb begin
        w_exec_data = r_data;
        unique case (r_op)
            OpLoad:  w_exec_data = r_mem[dptr];
            OpMove:  w_exec_data = busb;
            OpIncdp: w_exec_data = dptr + 1'b1;
            default: w_exec_data = r_data;
        endcase
    end

    assign w_accept  = (r_state == StIdle) && start;
    assign w_exec_wb = (r_state == StExec) && (r_op != OpStore);
    assign w_wb_addr = (r_op == OpIncdp) ? DptrReg : r_rd;
    // Reset is also gated here so an EXEC edge coinciding with reset never writes.
    assign w_mem_we  = (r_state == StExec) && (r_op == OpStore) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_op     <= OpLoad;
            r_rd     <= '0;
            r_rs     <= '0;
            r_data   <= '0;
            r_w_addr <= '0;
            r_w_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op <= op_t'(op);
                r_rd <= rd;
                r_rs <= rs;
            end
            // Write-port registers only change on entry to WB, so they hold elsewhere.
            if (w_exec_wb) begin
                r_data   <= w_exec_data;
                r_w_addr <= w_wb_addr;
                r_w_data <= w_exec_data;
            end
        end
    end

    // Data memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[dptr] <= a_in;
        end
    end

    assign r_addr = r_rs;
    assign w_addr = r_w_addr;
    assign w_data = r_w_data;
    assign wr_en  = (r_state == StWb);
    assign done   = (r_state == StDone);
    assign busy   = (r_state != StIdle);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes expected writes/done pulses with their
// cycle stamps, a negedge monitor pops and compares them.
module tb_load_store_unit;

    localparam int DW = 4;
    localparam int MEMSZ = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [2:0]    rd = 3'd0;
    logic [2:0]    rs = 3'd0;
    logic [DW-1:0] dptr = '0;
    logic [DW-1:0] a_in = '0;
    logic [DW-1:0] busb = '0;
    logic [2:0]    r_addr;
    logic          wr_en;
    logic [2:0]    w_addr;
    logic [DW-1:0] w_data;
    logic          busy;
    logic          done;

    load_store_unit #(.DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rd     (rd),
        .rs     (rs),
        .dptr   (dptr),
        .a_in   (a_in),
        .busb   (busb),
        .r_addr (r_addr),
        .wr_en  (wr_en),
        .w_addr (w_addr),
        .w_data (w_data),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_wr;
        int unsigned addr;
        int unsigned data;
        int unsigned at;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned mem_model [MEMSZ];
    int unsigned cur_rs = 0;

    function automatic void check(string name, int unsigned act, int unsigned req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void fail(string msg);
        total++;
        bad++;
        $display("FAIL %s (cyc %0d)", msg, cyc);
    endfunction

    function automatic void push(bit w, int unsigned a, int unsigned d, int unsigned at);
        exp_t e;
        e.is_wr = w;
        e.addr  = a;
        e.data  = d;
        e.at    = at;
        exp_q.push_back(e);
    endfunction

    // Reference behaviour: what the register bank and memory should see for one operation.
    function automatic void model(int unsigned o, int unsigned d, int unsigned p,
                                  int unsigned a, int unsigned b, int unsigned issue);
        case (o)
            0: begin push(1, d, mem_model[p], issue + 2); push(0, 0, 0, issue + 3); end
            1: begin mem_model[p] = a; push(0, 0, 0, issue + 2); end
            2: begin push(1, d, b, issue + 2); push(0, 0, 0, issue + 3); end
            default: begin push(1, 2, (p + 1) % MEMSZ, issue + 2); push(0, 0, 0, issue + 3); end
        endcase
    endfunction

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (busy) check("r_addr", r_addr, cur_rs);
        if (wr_en) begin
            if (exp_q.size() == 0 || !exp_q[0].is_wr) begin
                fail($sformatf("unexpected wr_en w_addr=%0d w_data=%0d", w_addr, w_data));
            end else begin
                e = exp_q.pop_front();
                check("w_addr", w_addr, e.addr);
                check("w_data", w_data, e.data);
                check("wr_cycle", cyc, e.at);
            end
        end
        if (done) begin
            if (exp_q.size() == 0 || exp_q[0].is_wr) begin
                fail("unexpected done");
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.at);
            end
        end
    end

    task automatic wait_done();
        bit got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) fail("timeout waiting for done");
    endtask

    task automatic run_op(input int unsigned o, input int unsigned d, input int unsigned s,
                          input int unsigned p, input int unsigned a, input int unsigned b,
                          input bit move_ptr);
        int unsigned issue;
        @(negedge clk);
        op     = 2'(o);
        rd     = 3'(d);
        rs     = 3'(s);
        dptr   = DW'(p);
        a_in   = DW'(a);
        busb   = DW'(b);
        start  = 1'b1;
        issue  = cyc;
        cur_rs = s;
        @(negedge clk);
        start = 1'b0;
        // Moving dptr after acceptance checks that the EXEC-edge value is the one used.
        if (move_ptr) dptr = DW'($urandom_range(0, MEMSZ - 1));
        model(o, d, int'(dptr), a, b, issue);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        int unsigned issue;
        int unsigned p;
        #3;
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_r_addr", r_addr, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_w_data", w_data, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < MEMSZ; i++) run_op(1, 0, 0, i, $urandom_range(0, 15), 0, 0);

        run_op(1, 0, 0, 3, 4'hA, 0, 0);
        run_op(0, 5, 0, 3, 0, 0, 0);
        run_op(2, 1, 7, 0, 0, 4'h6, 0);
        run_op(3, 6, 0, 4'hF, 0, 0, 0);

        // STORE with start held high from EXEC through DONE: only one op, MOVE after IDLE.
        @(negedge clk);
        op = 2'd1; rd = 3'd0; rs = 3'd4; dptr = 4'h7; a_in = 4'hC; start = 1'b1;
        issue = cyc;
        cur_rs = 4;
        model(1, 0, 7, 4'hC, 0, issue);
        @(negedge clk);
        op = 2'd2; rd = 3'd3; busb = 4'hB;
        push(1, 3, 4'hB, issue + 5);
        push(0, 0, 0, issue + 6);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset across the EXEC edge of a STORE must not write.
        run_op(1, 0, 0, 2, 4'h5, 0, 0);
        @(negedge clk);
        op = 2'd1; dptr = 4'h2; a_in = 4'h9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_exec_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_op(0, 4, 0, 2, 0, 0, 0);

        // Reset mid-WB of a LOAD drops outputs without a clock edge.
        @(negedge clk);
        p = $urandom_range(0, 15);
        op = 2'd0; rd = 3'd3; rs = 3'd6; dptr = DW'(p); start = 1'b1;
        issue = cyc;
        cur_rs = 6;
        @(negedge clk);
        start = 1'b0;
        push(1, 3, mem_model[p], issue + 2);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midwb_wr_en", wr_en, 0);
        check("midwb_busy", busy, 0);
        check("midwb_done", done, 0);
        check("midwb_r_addr", r_addr, 0);
        check("midwb_w_addr", w_addr, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;

        repeat (60) begin
            run_op($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
